systolic_result_drain: RTL
==========================

Name: systolic_result_drain

Overview:
- Consumer side of the systolic array result interface.
- On the rising edge of `compute_done`, snapshots the flat `output_matrix` bus and `cycles_count`.
- Streams the snapshot out as fixed-width beats over a valid/ready interface, in linear row-major order.
- Sits between `systolic_array` and the writeback/DMA path, so the array can be cleared and reused once the snapshot is taken.

Parameters:
- rows, 64, array rows (matrix M).
- cols, 64, array columns (matrix N).
- op_width, 32, bits per accumulator element.
- lanes, 8, elements per output beat; rows*cols must be divisible by lanes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- compute_done  in  1  array result-ready level; a rising edge starts capture.
- output_matrix  in  rows*cols*op_width  array results; element (r,c) at bits [(r*cols+c)*op_width +: op_width].
- cycles_count  in  32  array latency counter, captured with the data.
- m_valid  out  1  beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  lanes*op_width  beat payload; lane 0 in the LSBs.
- m_beat_idx  out  $clog2(rows*cols/lanes+1)  index of the current beat.
- m_last  out  1  final beat of the frame.
- busy  out  1  high while a frame is held or streaming.
- drain_done  out  1  one-cycle pulse after the last beat is accepted.
- overrun  out  1  sticky; a new compute_done edge arrived while busy.
- captured_cycles  out  32  cycles_count sampled at capture.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Beat counter = 0. compute_done edge detector history = 0. Snapshot contents undefined/don't-care.
- Edge detect: `start = compute_done & ~done_q`, where done_q is compute_done registered. A level held high for many cycles produces one start.
- IDLE, on start at edge N:
  - output_matrix and cycles_count are registered into the snapshot at edge N.
  - busy = 1 and m_valid = 1 from cycle N+1; beat 0 is presented in cycle N+1.
  - Capture latency is exactly 1 cycle.
- STREAM:
  - Total beat count B = rows*cols/lanes.
  - Beat b carries snapshot elements b*lanes .. b*lanes+lanes-1; element b*lanes+i sits in lane i.
  - m_beat_idx = b. m_last = (b == B-1).
  - Handshake: transfer occurs when m_valid & m_ready are both high at a posedge.
  - While m_valid is high and m_ready is low, m_data, m_beat_idx and m_last hold stable.
  - m_valid never drops before the last transfer. Throughput is 1 beat/cycle when m_ready is held high.
  - m_ready is ignored when m_valid is low.
- Last transfer at edge E:
  - Next state IDLE; m_valid, m_last, busy = 0 from E+1.
  - drain_done = 1 for cycle E+1 only.
  - A start seen at edge E+1 is accepted normally.
- Start while busy (including the same edge as the last transfer): the edge is ignored, the snapshot is not overwritten, and overrun is set.
  - overrun clears only on rst.
  - Note: done_q still tracks compute_done, so a level still high after IDLE returns does not restart.
- captured_cycles updates only on an accepted start and holds until the next one.
- rst asserted mid-frame: next cycle m_valid = 0, state IDLE, beat counter 0, no drain_done pulse. The partial frame is discarded.
- Beat counter wraps to 0 only via the IDLE transition; it never exceeds B-1.
- No arithmetic is performed on data. Element bits pass through unmodified, with no sign handling.

Optional Feature:
- Macro: DRAIN_TRAILER_EN.
- Defined:
  - One extra trailer beat follows data beat B-1, with m_beat_idx = B.
  - Trailer m_data[31:0] = captured_cycles, m_data[63:32] = B, remaining bits 0.
  - m_last is asserted on the trailer only, not on beat B-1.
  - drain_done follows acceptance of the trailer.
  - Requires lanes*op_width >= 64 (checked by an elaboration-time assertion).
- Undefined: no trailer; m_last is asserted on beat B-1; the m_beat_idx range still covers 0..B.

Test Plan:
- Config rows=2, cols=4, op_width=32, lanes=2 (B=4). Stimulus: output_matrix elements = 0x11,0x22,...,0x88 (element k = 0x11*(k+1)), cycles_count=0x1F4, compute_done pulsed 1 cycle, m_ready=1. Required response:
  - beats {0x22,0x11}, {0x44,0x33}, {0x66,0x55}, {0x88,0x77} on 4 consecutive cycles, starting 1 cycle after the edge;
  - m_last on beat 3; drain_done 1 cycle later; captured_cycles = 0x1F4.
- Backpressure: same frame, m_ready toggled 0,0,1,0,1,1,0,1. Required response: each beat is held stable while m_ready=0; all 4 beats arrive in order with none dropped or duplicated.
- Level-held done: compute_done held high 20 cycles. Required response: exactly one frame, no overrun, no restart after drain_done.
- Overrun: second compute_done rising edge during beat 1 with different output_matrix data. Required response: original data streams unchanged and overrun = 1 until rst.
- Reset mid-frame: rst asserted 1 cycle after beat 1 transfers. Required response: m_valid = 0 next cycle, no drain_done; a new start then streams from beat 0 with fresh data.
- With DRAIN_TRAILER_EN: 5 beats are produced, and the trailer (beat index 4) has m_data[63:0] = 0x00000004_000001F4 with m_last=1; with the macro undefined, m_last is on beat 3.

Source files
------------

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots array results on a compute_done rising edge and streams them as valid/ready beats (DRAIN_TRAILER_EN adds a trailer beat)
module systolic_result_drain #(
  parameter int rows     = 64,
  parameter int cols     = 64,
  parameter int op_width = 32,
  parameter int lanes    = 8
)(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   compute_done,
  input  logic [rows*cols*op_width-1:0]          output_matrix,
  input  logic [31:0]                            cycles_count,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [lanes*op_width-1:0]              m_data,
  output logic [$clog2(rows*cols/lanes+1)-1:0]   m_beat_idx,
  output logic                                   m_last,
  output logic                                   busy,
  output logic                                   drain_done,
  output logic                                   overrun,
  output logic [31:0]                            captured_cycles
);
  localparam int beats = rows*cols/lanes;
  localparam int bw    = lanes*op_width;
  localparam int iw    = $clog2(beats+1);
`ifdef DRAIN_TRAILER_EN
  localparam int last_idx = beats;
`else
  localparam int last_idx = beats-1;
`endif

  if (rows*cols % lanes != 0) begin : g_div_chk
    $error("rows*cols must be divisible by lanes");
  end
`ifdef DRAIN_TRAILER_EN
  if (bw < 64) begin : g_trailer_chk
    $error("trailer beat needs lanes*op_width >= 64");
  end
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       r_state, w_next;
  logic                         r_done_q, r_drain, r_overrun;
  logic [iw-1:0]                r_beat;
  logic [31:0]                  r_cyc;
  logic [rows*cols*op_width-1:0] r_snap;
  logic                         w_start, w_fire, w_last;
  logic [bw-1:0]                w_beat_data;
`ifdef DRAIN_TRAILER_EN
  logic [bw-1:0]                w_trailer;
`endif

  // edge detect, handshake decode, next state and output decode
  always_comb begin
    w_start     = compute_done & ~r_done_q;
    m_valid     = r_state == STREAM;
    busy        = m_valid;
    w_fire      = m_valid & m_ready;
    w_last      = r_beat == iw'(last_idx);
    w_next      = r_state == IDLE ? (w_start ? STREAM : IDLE) : (w_fire && w_last ? IDLE : STREAM);
    m_last      = m_valid & w_last;
    m_beat_idx  = r_beat;
    drain_done  = r_drain;
    overrun     = r_overrun;
    captured_cycles = r_cyc;
    w_beat_data = r_snap[int'(r_beat)*bw +: bw];
`ifdef DRAIN_TRAILER_EN
    w_trailer        = '0;
    w_trailer[31:0]  = r_cyc;
    w_trailer[63:32] = 32'(beats);
    m_data      = !m_valid ? '0 : r_beat == iw'(beats) ? w_trailer : w_beat_data;
`else
    m_data      = m_valid ? w_beat_data : '0;
`endif
  end

  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;

  // beat counter, snapshot capture, edge history and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_q  <= 1'b0;
      r_drain   <= 1'b0;
      r_overrun <= 1'b0;
      r_beat    <= '0;
      r_cyc     <= '0;
    end else begin
      r_done_q  <= compute_done;
      r_drain   <= w_fire & w_last;
      r_overrun <= r_overrun | (w_start & busy);
      r_beat    <= w_fire ? (w_last ? '0 : r_beat + 1'b1) : r_beat;
      if (r_state == IDLE && w_start) begin
        r_snap <= output_matrix;
        r_cyc  <= cycles_count;
      end
    end
  end
endmodule
